// File: rtl/cdc_xfer_ctrl.sv
// cdc_xfer_ctrl: single-clock receiver for a four-phase req/ack handshake
// arriving from a foreign clock domain. req_async goes through a two-flop
// synchroniser. data_in is never synchronised; it is only captured while the
// sender holds it stable under an asserted request.
// Optional feature: define XFER_CNT_EN to build the saturating transfer
// counter on xfer_cnt. Without it, xfer_cnt is tied to zero.
module cdc_xfer_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_async,
  input  logic [DW-1:0] data_in,
  output logic          ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_proto,
  output logic [7:0]    xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_s1;
  logic          r_req_s;
  logic          r_ack;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_err;
  logic          w_ack_nxt;
  logic          w_valid_nxt;
  logic          w_load;
  logic          w_err_set;

  // Two-flop synchroniser; the only place req_async is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_req_s <= 1'b0;
    end else begin
      r_s1    <= req_async;
      r_req_s <= r_s1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; sender withdrawal in HOLD wins over handshake
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_valid_nxt = r_out_valid;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_req_s) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!r_req_s) begin
          w_err_set   = 1'b1;
          w_valid_nxt = 1'b0;
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_out_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!r_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered handshake outputs, captured word and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ack       <= w_ack_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_load ? data_in : r_out_data;
      r_err       <= r_err | w_err_set;
    end
  end

`ifdef XFER_CNT_EN
  logic       w_xfer_done;
  logic [7:0] r_xfer_cnt;

  assign w_xfer_done = (r_state == S_ACK) && !r_req_s;

  // Saturating count of completed ACK-to-IDLE exits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_xfer_done && (r_xfer_cnt != '1)) begin
      r_xfer_cnt <= r_xfer_cnt + 8'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = '0;
`endif

  assign ack       = r_ack;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_proto = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
